// File: rtl/serial_addsub_nbit_pkg.sv
// serial_addsub_nbit_pkg: FSM state encodings and default width shared by the serial adder and its controller
package serial_addsub_nbit_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_addsub_nbit_if.sv
// serial_addsub_nbit_if: start/busy/done bus between controller and serial adder (ovf with SERIAL_ADDSUB_OVF_EN)
interface serial_addsub_nbit_if
  import serial_addsub_nbit_pkg::*;
#(parameter int WIDTH = DEF_WIDTH);
  logic start, sub, cout, busy, done;
  logic [WIDTH-1:0] a, b, sum;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf;
  modport master (output start, sub, a, b, input sum, cout, busy, done, ovf);
  modport slave (input start, sub, a, b, output sum, cout, busy, done, ovf);
`else
  modport master (output start, sub, a, b, input sum, cout, busy, done);
  modport slave (input start, sub, a, b, output sum, cout, busy, done);
`endif
endinterface

// File: rtl/serial_addsub_nbit_fa_cell.sv
// fa_cell: combinational 1-bit full adder reused once per clock by the serial datapath
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_addsub_nbit.sv
// serial_addsub_nbit: LSB-first bit-serial add/subtract, one bit per clock
// Optional signed overflow output enabled by SERIAL_ADDSUB_OVF_EN.
module serial_addsub_nbit
  import serial_addsub_nbit_pkg::*;
#(parameter int WIDTH = DEF_WIDTH) (
  input logic clk,
  input logic rst_n,
  serial_addsub_nbit_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, cout_q, cout_d, fa_s, fa_c, accept, last;
  fa_cell u_fa (.a_i(opa_q[0]), .b_i(opb_q[0]), .cin_i(carry_q), .sum_o(fa_s), .cout_o(fa_c));
  assign accept = (state_q != ST_SHIFT) && bus.start;
  assign last   = (state_q == ST_SHIFT) && (cnt_q == CNT_W'(WIDTH - 1));
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    if (accept) begin
      opa_d   = bus.a;
      opb_d   = bus.sub ? ~bus.b : bus.b;
      carry_d = bus.sub;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (state_q == ST_SHIFT) begin
      opa_d   = opa_q >> 1;
      opb_d   = opb_q >> 1;
      res_d   = {fa_s, res_q[WIDTH-1:1]};
      carry_d = fa_c;
      cnt_d   = cnt_q + CNT_W'(1);
      state_d = last ? ST_DONE : ST_SHIFT;
      sum_d   = last ? res_d : sum_q;
      cout_d  = last ? fa_c : cout_q;
    end else begin
      state_d = ST_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state_q == ST_SHIFT);
  assign bus.done = (state_q == ST_DONE);
`ifdef SERIAL_ADDSUB_OVF_EN
  // On the last bit carry_q is the carry into the MSB and fa_c the carry out of it.
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (last) ovf_q <= carry_q ^ fa_c;
  end
  assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_serial_addsub_nbit.sv
// tb_serial_addsub_nbit: table-driven vectors plus busy/back-to-back/reset sequences, WIDTH=4
module tb_serial_addsub_nbit;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  serial_addsub_nbit_if #(.WIDTH(W)) bus ();
  serial_addsub_nbit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [W-1:0] a, b;
    logic sub;
    logic [W-1:0] sum;
    logic cout, ovf;
  } vec_t;
  vec_t vecs [9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.a = a; bus.b = b; bus.sub = sub; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (!bus.done && cyc < 20) begin
      if (bus.busy) busy_cyc++;
      @(negedge clk);
      cyc++;
    end
  endtask
  initial begin
    int cyc, bc;
    vecs[0] = '{4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[1] = '{4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
    vecs[2] = '{4'd3, 4'd5, 1'b1, 4'd14, 1'b0, 1'b0};
    vecs[3] = '{4'd9, 4'd4, 1'b1, 4'd5, 1'b1, 1'b1};
    vecs[4] = '{4'd7, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1};
    vecs[5] = '{4'd3, 4'd2, 1'b0, 4'd5, 1'b0, 1'b0};
    vecs[6] = '{4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1};
    vecs[7] = '{4'd0, 4'd0, 1'b1, 4'd0, 1'b1, 1'b0};
    vecs[8] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0};
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_sum", 32'(bus.sum), 0);
    chk("reset_cout", 32'(bus.cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].sub);
      wait_done(cyc, bc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), W);
      chk($sformatf("v%0d_busy_cycles", i), 32'(bc), W);
      chk($sformatf("v%0d_sum", i), 32'(bus.sum), 32'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 32'(bus.cout), 32'(vecs[i].cout));
`ifdef SERIAL_ADDSUB_OVF_EN
      chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
`endif
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(bus.done), 0);
    end
    // start while busy is ignored; start in DONE cycle is accepted
    launch(4'd5, 4'd3, 1'b0);
    @(negedge clk);
    bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc, bc);
    chk("busy_start_latency", 32'(cyc + 2), W);
    chk("busy_start_sum", 32'(bus.sum), 8);
    bus.a = 4'd9; bus.b = 4'd4; bus.sub = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_busy", 32'(bus.busy), 1);
    chk("b2b_sum_held", 32'(bus.sum), 8);
    wait_done(cyc, bc);
    chk("b2b_gap", 32'(cyc + 1), 5);
    chk("b2b_sum", 32'(bus.sum), 5);
    chk("b2b_cout", 32'(bus.cout), 1);
    @(negedge clk);
    // reset mid-operation
    launch(4'd5, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sum", 32'(bus.sum), 0);
    chk("rst_cout", 32'(bus.cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) bc++;
    end
    chk("rst_no_done", 32'(bc), 0);
    launch(4'd6, 4'd2, 1'b0);
    wait_done(cyc, bc);
    chk("post_rst_latency", 32'(cyc), W);
    chk("post_rst_sum", 32'(bus.sum), 8);
    chk("post_rst_cout", 32'(bus.cout), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
